// File: rtl/rf_wbuf_lookup.sv
// Bypass search over pending register-file writes.
// Returns the data of the newest occupied entry whose address matches lookup_addr.
module rf_wbuf_lookup #(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4
) (
   input  logic [DEPTH*ADDR_WIDTH-1:0] ent_addr,
   input  logic [DEPTH*DATA_WIDTH-1:0] ent_data,
   input  logic [DEPTH-1:0]            occ,
   input  logic [$clog2(DEPTH)-1:0]    wr_ptr,
   input  logic [ADDR_WIDTH-1:0]       lookup_addr,
   output logic                        hit,
   output logic [DATA_WIDTH-1:0]       data
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_a;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_a;
   logic [PTR_W-1:0]                 slot;

   assign addr_a = ent_addr;
   assign data_a = ent_data;

   // Walk slots oldest (wr_ptr) to newest (wr_ptr-1); later matches overwrite earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      slot = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         slot = wr_ptr - PTR_W'(k);
         if (occ[slot] && (addr_a[slot] == lookup_addr)) begin
            hit  = 1'b1;
            data = data_a[slot];
         end
      end
   end
endmodule

// File: rtl/rf_write_buffer.sv
// In-order FIFO of pending register-file writes with a newest-match bypass lookup.
// Drains at most one entry per cycle onto the register file write port.
module rf_write_buffer #(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ADDR_WIDTH-1:0]        in_addr,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         stall,
   output logic                         rf_wen,
   output logic [ADDR_WIDTH-1:0]        rf_waddr,
   output logic [DATA_WIDTH-1:0]        rf_wdata,
   input  logic [ADDR_WIDTH-1:0]        lookup_addr,
   output logic                         lookup_hit,
   output logic [DATA_WIDTH-1:0]        lookup_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0][ADDR_WIDTH-1:0] mem_addr;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_data;
   logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
   logic [CNT_W-1:0]                 cnt;
   logic [DEPTH-1:0]                 occ;
   logic                             push, pop;

   assign count    = cnt;
   assign empty    = (cnt == '0);
   assign in_ready = (cnt != CNT_W'(DEPTH));
   // Reset cycle must never strobe a stale head into the register file.
   assign rf_wen   = !empty && !stall && !rst;
   assign push     = in_valid && in_ready;
   assign pop      = rf_wen;
   assign rf_waddr = mem_addr[rd_ptr];
   assign rf_wdata = mem_data[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_addr[wr_ptr] <= in_addr;
         mem_data[wr_ptr] <= in_data;
      end
   end

   // A slot is live when its distance from the head is below the occupancy.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_occ
         logic [PTR_W-1:0] rel;
         assign rel     = PTR_W'(gi) - rd_ptr;
         assign occ[gi] = (CNT_W'(rel) < cnt);
      end
   endgenerate

   rf_wbuf_lookup #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_lookup (
      .ent_addr    (mem_addr),
      .ent_data    (mem_data),
      .occ         (occ),
      .wr_ptr      (wr_ptr),
      .lookup_addr (lookup_addr),
      .hit         (lookup_hit),
      .data        (lookup_data)
   );
endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed bench for rf_write_buffer: DEPTH=4, 2-bit addresses, 8-bit data.
module tb_rf_write_buffer;
   localparam int AW = 2;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic          stall;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW-1:0] lookup_addr;
   logic          lookup_hit;
   logic [DW-1:0] lookup_data;
   logic [CW-1:0] count;
   logic          empty;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rf_write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_addr     (in_addr),
      .in_data     (in_data),
      .stall       (stall),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .lookup_addr (lookup_addr),
      .lookup_hit  (lookup_hit),
      .lookup_data (lookup_data),
      .count       (count),
      .empty       (empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked 1ns later.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic look(input string tag, input logic [AW-1:0] a, input logic h, input logic [DW-1:0] d);
      lookup_addr = a;
      #1;
      chk({tag, "_hit"}, 32'(lookup_hit), 32'(h));
      chk({tag, "_dat"}, 32'(lookup_data), 32'(d));
   endtask

   task automatic rfchk(input string tag, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      #1;
      chk({tag, "_wen"}, 32'(rf_wen), 32'(w));
      if (w) begin
         chk({tag, "_waddr"}, 32'(rf_waddr), 32'(a));
         chk({tag, "_wdata"}, 32'(rf_wdata), 32'(d));
      end
   endtask

   logic [AW-1:0] exp_a [5];
   logic [DW-1:0] exp_d [5];

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
      stall = 1'b0; lookup_addr = '0;
      repeat (2) @(posedge clk);

      // reset / idle
      cyc(); rst = 1'b0; #1;
      chk("rst_wen", 32'(rf_wen), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_count", 32'(count), 0);
      for (int a = 0; a < 4; a++) look("rst_look", AW'(a), 1'b0, 8'h00);

      // single write, one-cycle latency
      cyc(); in_valid = 1'b1; in_addr = 2'd1; in_data = 8'h01;
      rfchk("sw_n", 1'b0, 2'd0, 8'h00);
      cyc(); in_valid = 1'b0;
      rfchk("sw_n1", 1'b1, 2'd1, 8'h01);
      chk("sw_cnt1", 32'(count), 1);
      look("sw_look", 2'd1, 1'b1, 8'h01);
      cyc(); rfchk("sw_n2", 1'b0, 2'd0, 8'h00);
      chk("sw_cnt0", 32'(count), 0);

      // fill under stall
      exp_a = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3};
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(); in_valid = 1'b1; in_addr = exp_a[i]; in_data = exp_d[i];
      end
      cyc(); in_addr = exp_a[4]; in_data = exp_d[4]; #1;
      chk("full_cnt", 32'(count), 4);
      chk("full_ready", 32'(in_ready), 0);
      chk("full_wen", 32'(rf_wen), 0);
      look("full_l0", 2'd0, 1'b1, 8'h33);
      look("full_l1", 2'd1, 1'b1, 8'h22);
      look("full_l3", 2'd3, 1'b0, 8'h00);
      cyc(); #1;
      chk("held_cnt", 32'(count), 4);
      // release stall while fifth request still pending: no pass-through when full
      stall = 1'b0;
      rfchk("drain0", 1'b1, exp_a[0], exp_d[0]);
      chk("drain0_ready", 32'(in_ready), 0);
      cyc(); #1;
      chk("drain1_cnt", 32'(count), 3);
      chk("drain1_ready", 32'(in_ready), 1);
      rfchk("drain1", 1'b1, exp_a[1], exp_d[1]);
      cyc(); in_valid = 1'b0; #1;
      chk("drain2_cnt", 32'(count), 3);
      rfchk("drain2", 1'b1, exp_a[2], exp_d[2]);
      look("drain2_l3", 2'd3, 1'b1, 8'h55);
      look("drain2_l0", 2'd0, 1'b1, 8'h33);
      for (int i = 3; i < 5; i++) begin
         cyc(); rfchk("drain", 1'b1, exp_a[i], exp_d[i]);
         chk("drain_cnt", 32'(count), 32'(5 - i));
      end
      cyc(); rfchk("drain_done", 1'b0, 2'd0, 8'h00);
      chk("drain_empty", 32'(empty), 1);

      // continuous stream, pointer wrap
      for (int i = 0; i < 10; i++) begin
         cyc(); in_valid = 1'b1; in_addr = AW'(i % 4); in_data = DW'(8'hA0 + i);
         if (i == 0) begin
            rfchk("strm0", 1'b0, 2'd0, 8'h00);
            chk("strm0_cnt", 32'(count), 0);
         end else begin
            rfchk("strm", 1'b1, AW'((i - 1) % 4), DW'(8'hA0 + i - 1));
            chk("strm_cnt", 32'(count), 1);
         end
      end
      cyc(); in_valid = 1'b0;
      rfchk("strm_last", 1'b1, 2'd1, 8'hA9);
      cyc(); rfchk("strm_end", 1'b0, 2'd0, 8'h00);
      chk("strm_cnt0", 32'(count), 0);

      // reset with pending entries
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(); in_valid = 1'b1; in_addr = AW'(i + 1); in_data = DW'(8'h61 + i);
      end
      cyc(); in_valid = 1'b0; #1;
      chk("pre_rst_cnt", 32'(count), 3);
      look("pre_rst_l2", 2'd2, 1'b1, 8'h62);
      rst = 1'b1; stall = 1'b0;
      rfchk("rst_cyc", 1'b0, 2'd0, 8'h00);
      cyc(); rst = 1'b0; #1;
      chk("post_rst_cnt", 32'(count), 0);
      chk("post_rst_empty", 32'(empty), 1);
      look("post_rst_l2", 2'd2, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         rfchk("post_rst", 1'b0, 2'd0, 8'h00);
         cyc();
      end
      cyc(); in_valid = 1'b1; in_addr = 2'd3; in_data = 8'h7E;
      cyc(); in_valid = 1'b0;
      rfchk("post_rst_new", 1'b1, 2'd3, 8'h7E);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
